// File: rtl/toy_bus_dtcm_ctrl.sv
// DTCM target controller: request decode, SRAM drive, one inflight stage and a credit-protected
// response FIFO. Define TOY_BUS_DTCM_WR_ACK_EN to make in-range writes return a response.
module toy_bus_dtcm_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned SRAM_AW   = 14,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [DATA_W-1:0]   req_data,
    input  logic                req_opcode,
    input  logic [ID_W-1:0]     req_src_id,
    input  logic [ID_W-1:0]     req_tgt_id,
    output logic                sram_ce,
    output logic                sram_we,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W/8-1:0] sram_wstrb,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                rsp_vld,
    input  logic                rsp_rdy,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_opcode,
    output logic [ID_W-1:0]     rsp_src_id,
    output logic [ID_W-1:0]     rsp_tgt_id,
    output logic                rsp_err
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

    logic             in_range;
    logic             accept;
    logic             needs_rsp;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   used;
    logic             unused_addr;

    logic             infl_vld;
    logic             infl_op;
    logic             infl_err;
    logic [ID_W-1:0]  infl_src;
    logic [ID_W-1:0]  infl_tgt;

    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
    logic              fifo_op   [RSP_DEPTH];
    logic              fifo_err  [RSP_DEPTH];
    logic [ID_W-1:0]   fifo_src  [RSP_DEPTH];
    logic [ID_W-1:0]   fifo_tgt  [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr = ^req_addr[1:0];
    assign in_range    = (req_addr[ADDR_W-1:SRAM_AW+2] == '0);
    assign accept      = req_vld & req_rdy;

`ifdef TOY_BUS_DTCM_WR_ACK_EN
    assign needs_rsp = 1'b1;
`else
    // In-range writes are posted: no credit, no inflight slot, no response.
    assign needs_rsp = ~req_opcode | ~in_range;
`endif

    assign sram_ce    = accept & in_range;
    assign sram_we    = req_opcode;
    assign sram_addr  = req_addr[SRAM_AW+1:2];
    assign sram_wdata = req_data;
    assign sram_wstrb = req_strb;

    assign push = infl_vld;
    assign pop  = rsp_vld & rsp_rdy;

    // A pop this cycle frees a credit immediately, hence the rsp_rdy -> req_rdy path.
    assign used    = {1'b0, count} + (CNT_W + 1)'(infl_vld) - (CNT_W + 1)'(pop);
    assign req_rdy = ~rst & (used < (CNT_W + 1)'(RSP_DEPTH));

    assign rsp_vld    = (count != '0);
    assign rsp_data   = fifo_data[rd_ptr];
    assign rsp_opcode = fifo_op[rd_ptr];
    assign rsp_err    = fifo_err[rd_ptr];
    assign rsp_src_id = fifo_src[rd_ptr];
    assign rsp_tgt_id = fifo_tgt[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            infl_vld <= 1'b0;
            infl_op  <= 1'b0;
            infl_err <= 1'b0;
            infl_src <= '0;
            infl_tgt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_op[i]   <= 1'b0;
                fifo_err[i]  <= 1'b0;
                fifo_src[i]  <= '0;
                fifo_tgt[i]  <= '0;
            end
        end else begin
            infl_vld <= accept & needs_rsp;
            if (accept & needs_rsp) begin
                infl_op  <= req_opcode;
                infl_err <= ~in_range;
                infl_src <= req_tgt_id;
                infl_tgt <= req_src_id;
            end
            if (push) begin
                // SRAM read data is only valid during the stage-1 cycle, so capture it now.
                fifo_data[wr_ptr] <= (~infl_op & ~infl_err) ? sram_rdata : '0;
                fifo_op[wr_ptr]   <= infl_op;
                fifo_err[wr_ptr]  <= infl_err;
                fifo_src[wr_ptr]  <= infl_src;
                fifo_tgt[wr_ptr]  <= infl_tgt;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_toy_bus_dtcm_ctrl.sv
// Self-checking bench for toy_bus_dtcm_ctrl: table-driven request vectors plus hand sequences,
// with a scoreboard queue of expected responses filled on accept and drained on pop.
module tb_toy_bus_dtcm_ctrl;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int SRAM_AW   = 14;
    localparam int RSP_DEPTH = 2;

`ifdef TOY_BUS_DTCM_WR_ACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               req_vld;
    logic               req_rdy;
    logic [ADDR_W-1:0]  req_addr;
    logic [3:0]         req_strb;
    logic [DATA_W-1:0]  req_data;
    logic               req_opcode;
    logic [ID_W-1:0]    req_src_id;
    logic [ID_W-1:0]    req_tgt_id;
    logic               sram_ce;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_addr;
    logic [DATA_W-1:0]  sram_wdata;
    logic [3:0]         sram_wstrb;
    logic [DATA_W-1:0]  sram_rdata;
    logic               rsp_vld;
    logic               rsp_rdy;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_opcode;
    logic [ID_W-1:0]    rsp_src_id;
    logic [ID_W-1:0]    rsp_tgt_id;
    logic               rsp_err;

    toy_bus_dtcm_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .SRAM_AW(SRAM_AW), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_strb(req_strb),
        .req_data(req_data), .req_opcode(req_opcode), .req_src_id(req_src_id),
        .req_tgt_id(req_tgt_id),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_opcode(rsp_opcode),
        .rsp_src_id(rsp_src_id), .rsp_tgt_id(rsp_tgt_id), .rsp_err(rsp_err)
    );

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [3:0]  src;
        logic [3:0]  tgt;
        logic        x_ce;
        logic        x_we;
        logic [13:0] x_saddr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        op;
        logic [3:0]  src;
        logic [3:0]  tgt;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] exp_mem [logic [13:0]];
    logic [31:0] sram_mem [logic [13:0]];
    vec_t        vecs [9];
    int          tests, fails, stalls, pops, run, max_run;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural single-port SRAM with one-cycle read latency.
    logic [31:0] sm_w;
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                sm_w = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (sram_wstrb[b]) sm_w[8*b +: 8] = sram_wdata[8*b +: 8];
                sram_mem[sram_addr] = sm_w;
            end else begin
                sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 32'h0;
            end
        end
    end

    // Scoreboard: compare on pop, then predict on accept (expected data from the bench's own memory).
    rsp_t        m_exp;
    rsp_t        m_new;
    logic [13:0] m_idx;
    logic [31:0] m_w;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            run = 0;
        end else begin
            if (rsp_vld && rsp_rdy) begin
                pops++;
                run++;
                if (run > max_run) max_run = run;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got response data 0x%08h, expected none", rsp_data);
                end else begin
                    m_exp = sb.pop_front();
                    check("rsp_data", rsp_data, m_exp.data);
                    check("rsp_opcode", 32'(rsp_opcode), 32'(m_exp.op));
                    check("rsp_err", 32'(rsp_err), 32'(m_exp.err));
                    check("rsp_src_id", 32'(rsp_src_id), 32'(m_exp.src));
                    check("rsp_tgt_id", 32'(rsp_tgt_id), 32'(m_exp.tgt));
                end
            end else begin
                run = 0;
            end
            if (req_vld && req_rdy) begin
                m_idx     = req_addr[15:2];
                m_new.err = (req_addr[31:16] != 16'h0);
                m_new.op  = req_opcode;
                m_new.src = req_tgt_id;
                m_new.tgt = req_src_id;
                m_new.data = (!req_opcode && !m_new.err && exp_mem.exists(m_idx)) ?
                             exp_mem[m_idx] : 32'h0;
                if (!req_opcode || m_new.err || WRACK) sb.push_back(m_new);
                if (req_opcode && !m_new.err) begin
                    m_w = exp_mem.exists(m_idx) ? exp_mem[m_idx] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (req_strb[b]) m_w[8*b +: 8] = req_data[8*b +: 8];
                    exp_mem[m_idx] = m_w;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept cycle.
    task automatic send(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [3:0] src, input logic [3:0] tgt,
                        input bit chk, input logic x_ce, input logic x_we,
                        input logic [13:0] x_saddr);
        bit done;
        done       = 1'b0;
        req_vld    = 1'b1;
        req_opcode = op;
        req_addr   = addr;
        req_strb   = strb;
        req_data   = data;
        req_src_id = src;
        req_tgt_id = tgt;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                done = 1'b1;
                if (chk) begin
                    check("sram_ce", 32'(sram_ce), 32'(x_ce));
                    if (x_ce) begin
                        check("sram_we", 32'(sram_we), 32'(x_we));
                        check("sram_addr", 32'(sram_addr), 32'(x_saddr));
                        if (x_we) check("sram_wdata", sram_wdata, data);
                    end
                end
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got req_rdy=0 for 100 cycles, expected accept");
        end
        @(posedge clk);
        #1;
        req_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    int          acc, pops0;
    logic [31:0] snap;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 4'd3, 4'd1, 1'b1, 1'b1, 14'd4};
        vecs[1] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         4'd3, 4'd1, 1'b1, 1'b0, 14'd4};
        vecs[2] = '{1'b1, 32'h0000_0020, 4'h3, 32'h1234_5678, 4'd2, 4'd1, 1'b1, 1'b1, 14'd8};
        vecs[3] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         4'd2, 4'd1, 1'b1, 1'b0, 14'd8};
        vecs[4] = '{1'b0, 32'h0001_0000, 4'h0, 32'h0,         4'd5, 4'd1, 1'b0, 1'b0, 14'd0};
        vecs[5] = '{1'b1, 32'h8000_0004, 4'hF, 32'h1111_1111, 4'd6, 4'd1, 1'b0, 1'b0, 14'd0};
        vecs[6] = '{1'b0, 32'h0000_FFFC, 4'h0, 32'h0,         4'd7, 4'd1, 1'b1, 1'b0, 14'h3FFF};
        vecs[7] = '{1'b1, 32'h0000_FFFC, 4'h8, 32'hA500_0000, 4'd7, 4'd1, 1'b1, 1'b1, 14'h3FFF};
        vecs[8] = '{1'b0, 32'h0000_FFFC, 4'h0, 32'h0,         4'd7, 4'd1, 1'b1, 1'b0, 14'h3FFF};

        tests = 0; fails = 0; stalls = 0; pops = 0; run = 0; max_run = 0;
        rst = 1'b1; rsp_rdy = 1'b1; sram_rdata = 32'h0;
        req_vld = 1'b1; req_opcode = 1'b0; req_addr = 32'h10; req_strb = 4'h0;
        req_data = 32'h0; req_src_id = 4'd0; req_tgt_id = 4'd0;

        // Reset state, with a request pending to prove it is held off.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_sram_ce", 32'(sram_ce), 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_vld = 1'b0;

        // Write then read 0x10: response exactly two cycles after accept.
        send(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 4'd3, 4'd1, 1'b1, 1'b1, 1'b1, 14'd4);
        repeat (4) @(posedge clk); #1;
        send(1'b0, 32'h10, 4'h0, 32'h0, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 14'd4);
        @(negedge clk);
        check("lat_n1_rsp_vld", 32'(rsp_vld), 32'd0);
        @(negedge clk);
        check("lat_n2_rsp_vld", 32'(rsp_vld), 32'd1);
        check("lat_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("lat_rsp_tgt_id", 32'(rsp_tgt_id), 32'd3);
        check("lat_rsp_src_id", 32'(rsp_src_id), 32'd1);
        check("lat_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            send(vecs[i].op, vecs[i].addr, vecs[i].strb, vecs[i].data, vecs[i].src, vecs[i].tgt,
                 1'b1, vecs[i].x_ce, vecs[i].x_we, vecs[i].x_saddr);
        repeat (6) @(posedge clk); #1;

        // Back-to-back reads at full rate.
        stalls = 0; max_run = 0;
        for (int i = 0; i < 8; i++)
            send(1'b0, 32'h10 + 32'(4 * i), 4'h0, 32'h0, 4'(i), 4'd1, 1'b0, 1'b0, 1'b0, 14'd0);
        repeat (4) @(posedge clk); #1;
        check("b2b_stalls", 32'(stalls), 32'd0);
        check("b2b_consecutive_rsp", 32'(max_run >= 8), 32'd1);

        // Posted versus acknowledged writes.
        pops0 = pops;
        for (int i = 0; i < 4; i++)
            send(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i), 4'd2, 4'd1,
                 1'b0, 1'b0, 1'b0, 14'd0);
        send(1'b0, 32'h104, 4'h0, 32'h0, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 14'd0);
        repeat (8) @(posedge clk); #1;
        check("wr_rsp_count", 32'(pops - pops0), WRACK ? 32'd5 : 32'd1);

        // Backpressure: credits limit acceptance to RSP_DEPTH.
        rsp_rdy = 1'b0; acc = 0;
        req_vld = 1'b1; req_opcode = 1'b0; req_addr = 32'h100; req_src_id = 4'd9;
        req_tgt_id = 4'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_rdy) acc++;
            @(posedge clk); #1;
        end
        check("bp_accepted", 32'(acc), 32'(RSP_DEPTH));
        @(negedge clk);
        check("bp_req_rdy_low", 32'(req_rdy), 32'd0);
        check("bp_rsp_vld", 32'(rsp_vld), 32'd1);
        snap = rsp_data;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_rsp_stable", rsp_data, snap);
        @(posedge clk); #1;
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("bp_pop_frees_credit", 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        @(negedge clk);
        check("bp_req_rdy_relow", 32'(req_rdy), 32'd0);
        @(posedge clk); #1;
        req_vld = 1'b0;

        // Reset with work outstanding: everything is discarded.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("post_rst_rsp_data", rsp_data, 32'h0);
        @(posedge clk); #1;
        rsp_rdy = 1'b1;
        pops0 = pops;
        repeat (5) @(posedge clk); #1;
        check("no_stale_rsp", 32'(pops - pops0), 32'd0);
        send(1'b0, 32'h10, 4'h0, 32'h0, 4'd4, 4'd1, 1'b1, 1'b1, 1'b0, 14'd4);
        repeat (4) @(posedge clk); #1;
        check("post_rst_read", 32'(pops - pops0), 32'd1);

        repeat (5) @(posedge clk); #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
